alu_program_sequencer: RTL and testbench

//  Micro-sequencer that runs a short stored program of {op, imm} steps on a
//  4-bit accumulator through the shared combinational ALU.
//  - Host loads steps one at a time, then pulses start.
//  - Block executes one step per clock, then raises done with the final acc.
//  - Sits between the pin interface (ui_in/uio_in) and the ALU + 7-seg decode.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_core.sv | 30 +++
 rtl/alu_program_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_program_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and default widths for the ALU and its program sequencer.
package alu_pkg;

  localparam int unsigned DefaultDataW = 4;
  localparam int unsigned DefaultOpW   = 4;

  typedef enum logic [3:0] {
    OpAdd  = 4'h0,
    OpSub  = 4'h1,
    OpAnd  = 4'h2,
    OpOr   = 4'h3,
    OpEq   = 4'h4,
    OpNot  = 4'h5,
    OpGt   = 4'h6,
    OpLt   = 4'h7,
    OpHalt = 4'hF
  } alu_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } seq_state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: y = op(a, b), all results modulo 2^DATA_W.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned OP_W   = DefaultOpW
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] y
);

  // Opcode decode; compares yield all-ones for true, undefined opcodes yield 0.
  always_comb begin
    y = '0;
    case (op)
      OP_W'(OpAdd): y = a + b;
      OP_W'(OpSub): y = a - b;
      OP_W'(OpAnd): y = a & b;
      OP_W'(OpOr):  y = a | b;
      OP_W'(OpEq):  y = (a == b) ? '1 : '0;
      OP_W'(OpNot): y = ~a;
      OP_W'(OpGt):  y = (a > b) ? '1 : '0;
      OP_W'(OpLt):  y = (a < b) ? '1 : '0;
      default:      y = '0;
    endcase
  end

endmodule

// File: rtl/alu_program_sequencer.sv
// Micro-sequencer: host loads {op, imm} steps, then start runs them one per clock
// on an accumulator through alu_core, finishing in DONE with the result held.
module alu_program_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned OP_W   = DefaultOpW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     clear,
  input  logic                     load_valid,
  input  logic [OP_W-1:0]          load_op,
  input  logic [DATA_W-1:0]        load_imm,
  input  logic                     start,
  input  logic [DATA_W-1:0]        acc_init,
  output logic [DATA_W-1:0]        acc_out,
  output logic                     busy,
  output logic                     done,
  output logic                     prog_full,
  output logic [$clog2(DEPTH)-1:0] pc
);

  localparam int unsigned PcW   = $clog2(DEPTH);
  localparam int unsigned StepW = OP_W + DATA_W;
  localparam logic [PcW:0] FullLen = (PcW + 1)'(DEPTH);
  localparam logic [PcW:0] OneLen  = (PcW + 1)'(1);

  seq_state_t        state_q, state_d;
  logic [StepW-1:0]  prog_q [DEPTH];
  logic [PcW:0]      len_q, len_d;
  logic [PcW-1:0]    pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              wr_en;
  logic              full;
  logic              last_step;
  logic              is_halt;
  logic [OP_W-1:0]   cur_op;
  logic [DATA_W-1:0] cur_imm;
  logic [DATA_W-1:0] alu_y;

  assign {cur_op, cur_imm} = prog_q[pc_q];
  assign full      = (len_q == FullLen);
  assign last_step = ({1'b0, pc_q} == (len_q - OneLen));
  assign is_halt   = (cur_op == OP_W'(OpHalt));

  alu_core #(
    .DATA_W(DATA_W),
    .OP_W  (OP_W)
  ) u_alu (
    .a (acc_q),
    .b (cur_imm),
    .op(cur_op),
    .y (alu_y)
  );

  // State register; ena low freezes the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Next state: clear beats start; start/load are ignored while running.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) state_d = (len_q == '0) ? StDone : StRun;
        end
        StRun: begin
          if (is_halt || last_step) state_d = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StRun:   busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next state: accumulator, step index, program length and slot write.
  always_comb begin
    acc_d = acc_q;
    pc_d  = pc_q;
    len_d = len_q;
    wr_en = 1'b0;
    if (clear) begin
      // Accumulator is deliberately kept so the last result stays visible.
      len_d = '0;
      pc_d  = '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            acc_d = acc_init;
            pc_d  = '0;
          end else if (load_valid && !full) begin
            wr_en = 1'b1;
            len_d = len_q + OneLen;
          end
        end
        StRun: begin
          // HALT leaves acc and pc untouched; pc also parks on the final step.
          if (!is_halt) begin
            acc_d = alu_y;
            if (!last_step) pc_d = pc_q + PcW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers and program store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      pc_q  <= '0;
      len_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) prog_q[i] <= '0;
    end else if (ena) begin
      acc_q <= acc_d;
      pc_q  <= pc_d;
      len_q <= len_d;
      if (wr_en) prog_q[len_q[PcW-1:0]] <= {load_op, load_imm};
    end
  end

  assign acc_out   = acc_q;
  assign pc        = pc_q;
  assign prog_full = full;

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Directed bench for alu_program_sequencer with hand-computed expectations.
module tb_alu_program_sequencer;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       clear = 1'b0;
  logic       load_valid = 1'b0;
  logic [3:0] load_op = '0;
  logic [3:0] load_imm = '0;
  logic       start = 1'b0;
  logic [3:0] acc_init = '0;
  logic [3:0] acc_out;
  logic       busy;
  logic       done;
  logic       prog_full;
  logic [2:0] pc;

  int n_checks = 0;
  int n_pass   = 0;
  int edges;

  alu_program_sequencer #(
    .DEPTH (DEPTH),
    .DATA_W(4),
    .OP_W  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .clear     (clear),
    .load_valid(load_valid),
    .load_op   (load_op),
    .load_imm  (load_imm),
    .start     (start),
    .acc_init  (acc_init),
    .acc_out   (acc_out),
    .busy      (busy),
    .done      (done),
    .prog_full (prog_full),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] op, input logic [3:0] imm);
    load_valid = 1'b1;
    load_op    = op;
    load_imm   = imm;
    step();
    load_valid = 1'b0;
  endtask

  task automatic go(input logic [3:0] init);
    start    = 1'b1;
    acc_init = init;
    step();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (!done && n < max) begin
      step();
      n++;
    end
  endtask

  initial begin
    #12;
    // Reset state.
    check("rst_acc", acc_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_full", prog_full, 0);
    check("rst_pc", pc, 0);
    rst_n = 1'b1;
    step();

    // ADD 3, SUB 1, NOT 0 from 5: 8, 7, 8.
    load(4'h0, 4'd3);
    load(4'h1, 4'd1);
    load(4'h5, 4'd0);
    go(4'd5);
    check("p1_seed", acc_out, 5);
    check("p1_busy", busy, 1);
    step();
    check("p1_s0", acc_out, 8);
    check("p1_pc1", pc, 1);
    step();
    check("p1_s1", acc_out, 7);
    check("p1_notdone", done, 0);
    step();
    check("p1_s2", acc_out, 8);
    check("p1_done", done, 1);
    check("p1_busy_lo", busy, 0);
    check("p1_pc_end", pc, 2);

    // Wrap: ADD 1 from 15, then SUB 1 from 0, rerun and append in DONE.
    do_clear();
    check("clr_done", done, 0);
    load(4'h0, 4'd1);
    go(4'd15);
    step();
    check("wrap_add", acc_out, 0);
    do_clear();
    load(4'h1, 4'd1);
    go(4'd0);
    step();
    check("wrap_sub", acc_out, 15);
    check("wrap_done", done, 1);
    go(4'd3);
    check("rerun_busy", busy, 1);
    step();
    check("rerun_acc", acc_out, 2);
    load(4'h0, 4'd4);
    go(4'd0);
    step();
    step();
    check("append_acc", acc_out, 3);
    check("append_done", done, 1);
    check("append_pc", pc, 1);

    // HALT stops after two steps.
    do_clear();
    load(4'h0, 4'd2);
    load(4'hF, 4'd0);
    load(4'h0, 4'd4);
    go(4'd1);
    step();
    check("halt_s0", done, 0);
    step();
    check("halt_done", done, 1);
    check("halt_acc", acc_out, 3);
    check("halt_pc", pc, 1);

    // Remaining ALU ops through short programs.
    do_clear();
    load(4'h3, 4'd4);   // 9|4  = 13
    load(4'h2, 4'd6);   // 13&6 = 4
    load(4'h6, 4'd3);   // 4>3  -> 15
    load(4'h4, 4'd15);  // eq   -> 15
    load(4'h7, 4'd2);   // 15<2 -> 0
    load(4'h9, 4'd0);   // undefined -> 0
    load(4'h0, 4'd6);   // 6
    load(4'h7, 4'd9);   // 6<9 -> 15
    check("ops_full", prog_full, 1);
    go(4'd9);
    step();
    check("op_or", acc_out, 13);
    step();
    check("op_and", acc_out, 4);
    step();
    check("op_gt", acc_out, 15);
    step();
    check("op_eq", acc_out, 15);
    step();
    check("op_lt_false", acc_out, 0);
    go_dummy_free: begin end
    step();
    check("op_undef", acc_out, 0);
    step();
    step();
    check("op_lt_true", acc_out, 15);
    check("ops_done", done, 1);

    // Overfill: DEPTH loads fill, the extra is dropped.
    do_clear();
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i == int'(DEPTH) - 1) check("full_before", prog_full, 0);
      load(4'h0, 4'd1);
    end
    check("full_after", prog_full, 1);
    load(4'h1, 4'd5);
    go(4'd0);
    wait_done(20, edges);
    check("full_edges", edges, DEPTH);
    check("full_acc", acc_out, 8);
    check("full_pc", pc, DEPTH - 1);

    // Empty program finishes on the start edge.
    do_clear();
    go(4'd9);
    check("empty_done", done, 1);
    check("empty_busy", busy, 0);
    check("empty_acc", acc_out, 9);

    // Asynchronous reset mid-run.
    do_clear();
    load(4'h0, 4'd1);
    load(4'h0, 4'd1);
    load(4'h0, 4'd1);
    go(4'd0);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_acc", acc_out, 0);
    check("arst_busy", busy, 0);
    check("arst_pc", pc, 0);
    #1 rst_n = 1'b1;
    go(4'd7);
    check("arst_empty_done", done, 1);
    check("arst_empty_acc", acc_out, 7);

    // Clear mid-run.
    do_clear();
    load(4'h0, 4'd1);
    load(4'h0, 4'd1);
    load(4'h0, 4'd1);
    go(4'd0);
    step();
    do_clear();
    check("mclr_busy", busy, 0);
    check("mclr_done", done, 0);
    check("mclr_acc", acc_out, 1);
    check("mclr_pc", pc, 0);

    // ena low for three cycles freezes the run.
    load(4'h0, 4'd1);
    load(4'h0, 4'd1);
    load(4'h0, 4'd1);
    go(4'd0);
    step();
    ena = 1'b0;
    step();
    step();
    step();
    check("ena_acc", acc_out, 1);
    check("ena_pc", pc, 1);
    check("ena_busy", busy, 1);
    ena = 1'b1;
    wait_done(10, edges);
    check("ena_edges", edges, 2);
    check("ena_final", acc_out, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
